// File: rtl/psram_req_queue.sv
// psram_req_queue: request FIFO and single-outstanding command sequencer that
// sits in front of PsramController. Requests are queued, issued one at a time
// as one-cycle mem_read/mem_write pulses, and read data is returned in order.
// Optional feature macro: PSRAM_REQ_TIMEOUT_EN builds a watchdog that forces
// completion of a hung transaction after TIMEOUT cycles and raises err.
module psram_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [21:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [7:0]  rsp_byte,
    output logic        rsp_err,
    output logic        err,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte_write,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_busy
);

    localparam int PW = $clog2(DEPTH);

    // Parameter sanity: the pointers wrap naturally only for a power-of-two depth,
    // and the watchdog needs room for ISSUE and GUARD before it can fire.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("psram_req_queue: DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 3) begin : g_bad_timeout
        $error("psram_req_queue: TIMEOUT must be at least 3");
    end

    typedef struct packed {
        logic        write;
        logic        bytew;
        logic [21:0] addr;
        logic [15:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT
    } state_t;

    entry_t         fifo_mem [DEPTH];
    entry_t         head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic           push;
    logic           pop;
    logic           timed_out;
    logic           timeout_hit;
    logic           cur_write;
    state_t         state;
    state_t         next_state;

    assign req_ready = (count < (PW + 1)'(DEPTH));
    assign push      = req_valid && req_ready;
    assign head      = fifo_mem[rd_ptr];

    assign mem_read  = (state == ST_ISSUE) && !cur_write;
    assign mem_write = (state == ST_ISSUE) && cur_write;

    // Queue storage: written on push only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: req_write, bytew: req_byte,
                                  addr: req_addr, wdata: req_wdata};
        end
    end

    // Queue pointers and occupancy; a pop frees a slot only from the next cycle on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Sequencer next state: issue only when the controller is idle, skip busy for
    // one cycle after the pulse, then complete normally or by watchdog.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0 && !mem_busy) next_state = ST_ISSUE;
            end
            ST_ISSUE: next_state = ST_GUARD;
            ST_GUARD: next_state = ST_WAIT;
            ST_WAIT: begin
                if (!mem_busy) begin
                    pop        = 1'b1;
                    next_state = ST_IDLE;
                end else if (timeout_hit) begin
                    pop        = 1'b1;
                    timed_out  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Latch the head entry into the controller-facing registers at issue time so
    // they stay stable until completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr       <= '0;
            mem_din        <= '0;
            mem_byte_write <= 1'b0;
            cur_write      <= 1'b0;
        end else if (state == ST_IDLE && next_state == ST_ISSUE) begin
            mem_addr       <= head.addr;
            mem_din        <= head.bytew ? {head.wdata[7:0], head.wdata[7:0]} : head.wdata;
            mem_byte_write <= head.bytew;
            cur_write      <= head.write;
        end
    end

    // Read response: one-cycle pulse with the data sampled on the completing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_byte  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (pop && !cur_write) begin
                rsp_valid <= 1'b1;
                if (timed_out) begin
                    rsp_rdata <= '0;
                    rsp_byte  <= '0;
                end else begin
                    rsp_rdata <= mem_dout;
                    rsp_byte  <= mem_addr[0] ? mem_dout[15:8] : mem_dout[7:0];
                end
            end
        end
    end

`ifdef PSRAM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr;

    // Cycles since ISSUE; held at zero while idle and saturating at its maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr <= '0;
        end else if (state == ST_IDLE) begin
            tmr <= '0;
        end else if (tmr != {TW{1'b1}}) begin
            tmr <= tmr + TW'(1);
        end
    end

    assign timeout_hit = (tmr >= TW'(TIMEOUT - 1));

    // Error flags: rsp_err marks a forced read response, err stays set until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err <= 1'b0;
            err     <= 1'b0;
        end else begin
            rsp_err <= pop && timed_out && !cur_write;
            if (timed_out) err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_psram_req_queue.sv
// tb_psram_req_queue: directed self-checking bench for psram_req_queue with a
// small behavioural controller model (busy hold counter plus a tiny memory).
module tb_psram_req_queue;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [21:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0]  rsp_byte;
    logic        rsp_err;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte_write;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_busy;

    int total = 0;
    int bad   = 0;

    // Controller model controls
    int   hold_cycles = 3;
    logic init_busy   = 1'b1;
    logic stuck       = 1'b0;
    int   busy_cnt    = 0;
    logic [15:0] model_mem [64];

    // Monitor state
    int wr_pulses = 0;
    int rd_pulses = 0;
    int rsp_cnt   = 0;
    int overlap   = 0;
    logic [15:0] last_din = '0;
    logic        last_bw  = 1'b0;
    logic [21:0] issue_hist [$];
    logic [15:0] rsp_data_hist [$];
    logic [7:0]  rsp_byte_hist [$];

    psram_req_queue #(.DEPTH(4), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_byte(rsp_byte),
        .rsp_err(rsp_err), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_write(mem_byte_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: busy rises the cycle after a command pulse and holds for
    // hold_cycles; writes land in a small word memory indexed by the low address bits.
    always @(posedge clk) begin
        if (mem_read || mem_write) busy_cnt <= hold_cycles;
        else if (busy_cnt > 0)     busy_cnt <= busy_cnt - 1;
        if (mem_write) model_mem[mem_addr[5:0]] <= mem_din;
    end

    assign mem_busy = init_busy | stuck | (busy_cnt != 0);
    assign mem_dout = model_mem[mem_addr[5:0]];

    // Monitor: record command pulses and responses away from the active edge.
    always @(negedge clk) begin
        if ((mem_read || mem_write) && busy_cnt != 0) overlap++;
        if (mem_write) begin
            wr_pulses++;
            last_din = mem_din;
            last_bw  = mem_byte_write;
            issue_hist.push_back(mem_addr);
        end
        if (mem_read) begin
            rd_pulses++;
            issue_hist.push_back(mem_addr);
        end
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_data_hist.push_back(rsp_rdata);
            rsp_byte_hist.push_back(rsp_byte);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge and hold it until the next negedge (pushed
    // at the posedge between); waits for space first, bounded.
    task automatic applyStimulus(input logic w, input logic b, input logic [21:0] a,
                                 input logic [15:0] d);
        int guard = 0;
        while (!req_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) checkOutput("push_wait_bound", 32'(guard), 32'(0));
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic waitRsp(input int target, input string tag);
        int guard = 0;
        while (rsp_cnt < target && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, 32'(rsp_cnt >= target), 32'(1));
    endtask

    task automatic waitRead(input string tag);
        int guard = 0;
        while (!mem_read && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, 32'(mem_read), 32'(1));
    endtask

    initial begin
        int wr0;
        int rd0;
        int rs0;
        int ih0;
        int n;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        waitCycles(3);

        // Reset values
        checkOutput("rst_req_ready", 32'(req_ready), 32'(1));
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("rst_rsp_err",   32'(rsp_err),   32'(0));
        checkOutput("rst_err",       32'(err),       32'(0));
        checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        checkOutput("rst_rsp_byte",  32'(rsp_byte),  32'(0));
        checkOutput("rst_mem_cmd",   32'({mem_read, mem_write, mem_byte_write}), 32'(0));
        checkOutput("rst_mem_addr",  32'(mem_addr),  32'(0));
        checkOutput("rst_mem_din",   32'(mem_din),   32'(0));
        reset = 1'b0;
        waitCycles(2);

        // Controller initialisation: a queued write must wait for busy to fall
        $display("[TB] init busy hold");
        wr0 = wr_pulses;
        applyStimulus(1'b1, 1'b0, 22'h000020, 16'h1111);
        waitCycles(100);
        checkOutput("init_no_write", 32'(wr_pulses - wr0), 32'(0));
        init_busy = 1'b0;
        waitCycles(20);
        checkOutput("init_one_write", 32'(wr_pulses - wr0), 32'(1));

        // Word write then read back
        $display("[TB] word write/read");
        wr0 = wr_pulses;
        applyStimulus(1'b1, 1'b0, 22'h000010, 16'hA55A);
        waitCycles(15);
        checkOutput("ww_pulse",   32'(wr_pulses - wr0), 32'(1));
        checkOutput("ww_din",     32'(last_din), 32'h0000A55A);
        checkOutput("ww_bytew",   32'(last_bw),  32'(0));
        rs0 = rsp_cnt;
        applyStimulus(1'b0, 1'b0, 22'h000010, 16'h0000);
        waitRsp(rs0 + 1, "wr_rsp_seen");
        waitCycles(5);
        checkOutput("wr_rsp_count", 32'(rsp_cnt - rs0), 32'(1));
        checkOutput("wr_rsp_rdata", 32'(rsp_data_hist[rs0]), 32'h0000A55A);

        // Byte write replicates the low byte; odd-address read returns the high lane
        $display("[TB] byte write/read");
        applyStimulus(1'b1, 1'b1, 22'h000003, 16'h00C3);
        waitCycles(15);
        checkOutput("bw_din",   32'(last_din), 32'h0000C3C3);
        checkOutput("bw_bytew", 32'(last_bw),  32'(1));
        rs0 = rsp_cnt;
        applyStimulus(1'b0, 1'b0, 22'h000003, 16'h0000);
        waitRsp(rs0 + 1, "br_rsp_seen");
        checkOutput("br_rsp_byte",  32'(rsp_byte_hist[rs0]), 32'h000000C3);
        checkOutput("br_rsp_rdata", 32'(rsp_data_hist[rs0]), 32'h0000C3C3);

        // Six back-to-back requests with a slow controller
        $display("[TB] back-to-back burst");
        hold_cycles = 10;
        ih0 = issue_hist.size();
        rs0 = rsp_cnt;
        applyStimulus(1'b1, 1'b0, 22'h000004, 16'h1234);
        applyStimulus(1'b1, 1'b0, 22'h000005, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 22'h000004, 16'h0000);
        applyStimulus(1'b0, 1'b0, 22'h000005, 16'h0000);
        checkOutput("burst_full", 32'(req_ready), 32'(0));
        applyStimulus(1'b0, 1'b0, 22'h000010, 16'h0000);
        applyStimulus(1'b0, 1'b0, 22'h000003, 16'h0000);
        waitRsp(rs0 + 4, "burst_rsp_seen");
        waitCycles(5);
        checkOutput("burst_issues", 32'(issue_hist.size() - ih0), 32'(6));
        checkOutput("burst_iss0", 32'(issue_hist[ih0 + 0]), 32'h004);
        checkOutput("burst_iss1", 32'(issue_hist[ih0 + 1]), 32'h005);
        checkOutput("burst_iss2", 32'(issue_hist[ih0 + 2]), 32'h004);
        checkOutput("burst_iss3", 32'(issue_hist[ih0 + 3]), 32'h005);
        checkOutput("burst_iss4", 32'(issue_hist[ih0 + 4]), 32'h010);
        checkOutput("burst_iss5", 32'(issue_hist[ih0 + 5]), 32'h003);
        checkOutput("burst_rsp0", 32'(rsp_data_hist[rs0 + 0]), 32'h1234);
        checkOutput("burst_rsp1", 32'(rsp_data_hist[rs0 + 1]), 32'hBEEF);
        checkOutput("burst_rsp2", 32'(rsp_data_hist[rs0 + 2]), 32'hA55A);
        checkOutput("burst_rsp3", 32'(rsp_data_hist[rs0 + 3]), 32'hC3C3);
        checkOutput("burst_byte0", 32'(rsp_byte_hist[rs0 + 0]), 32'h34);
        checkOutput("burst_byte1", 32'(rsp_byte_hist[rs0 + 1]), 32'hBE);
        checkOutput("burst_byte2", 32'(rsp_byte_hist[rs0 + 2]), 32'h5A);
        checkOutput("burst_byte3", 32'(rsp_byte_hist[rs0 + 3]), 32'hC3);
        checkOutput("burst_overlap", 32'(overlap), 32'(0));
        hold_cycles = 3;

`ifdef PSRAM_REQ_TIMEOUT_EN
        // Watchdog: busy sticks high after a read issue
        $display("[TB] watchdog timeout");
        applyStimulus(1'b0, 1'b0, 22'h000010, 16'h0000);
        waitRead("to_read_issue");
        stuck = 1'b1;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_latency", 32'(n), 32'(32));
        checkOutput("to_rsp_err", 32'(rsp_err), 32'(1));
        checkOutput("to_rsp_rdata", 32'(rsp_rdata), 32'(0));
        waitCycles(1);
        checkOutput("to_err_set", 32'(err), 32'(1));
        wr0 = wr_pulses;
        applyStimulus(1'b1, 1'b0, 22'h000020, 16'h2222);
        waitCycles(20);
        checkOutput("to_next_waits", 32'(wr_pulses - wr0), 32'(0));
        stuck = 1'b0;
        waitCycles(20);
        checkOutput("to_next_issued", 32'(wr_pulses - wr0), 32'(1));
        checkOutput("to_err_sticky", 32'(err), 32'(1));
`else
        checkOutput("no_wd_err", 32'({err, rsp_err}), 32'(0));
`endif

        // Reset during WAIT of a read abandons it silently
        $display("[TB] reset mid-transaction");
        hold_cycles = 20;
        applyStimulus(1'b0, 1'b0, 22'h000004, 16'h0000);
        waitRead("mr_read_issue");
        waitCycles(5);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("mr_req_ready", 32'(req_ready), 32'(1));
        checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("mr_mem_cmd",   32'({mem_read, mem_write, mem_byte_write}), 32'(0));
        checkOutput("mr_mem_addr",  32'(mem_addr), 32'(0));
        checkOutput("mr_mem_din",   32'(mem_din), 32'(0));
        checkOutput("mr_rsp_data",  32'({rsp_rdata, rsp_byte}), 32'(0));
        checkOutput("mr_err",       32'({err, rsp_err}), 32'(0));
        rs0 = rsp_cnt;
        wr0 = wr_pulses;
        rd0 = rd_pulses;
        waitCycles(1);
        reset = 1'b0;
        waitCycles(40);
        checkOutput("mr_no_rsp",   32'(rsp_cnt - rs0), 32'(0));
        checkOutput("mr_no_issue", 32'((wr_pulses - wr0) + (rd_pulses - rd0)), 32'(0));
        checkOutput("mr_empty",    32'(req_ready), 32'(1));

        // Normal operation resumes after reset
        hold_cycles = 3;
        rs0 = rsp_cnt;
        applyStimulus(1'b0, 1'b0, 22'h000005, 16'h0000);
        waitRsp(rs0 + 1, "post_rst_rsp_seen");
        checkOutput("post_rst_rdata", 32'(rsp_data_hist[rs0]), 32'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
